// File: rtl/rule_pkg.sv
// rule_pkg: rule-ID set geometry and intersect FSM encoding, shared with the SP/DP range match trees
package rule_pkg;
  localparam int NUM_RULE_ID    = 8;
  localparam int RULE_ID_WIDTH  = 3;
  localparam int SLOT_W         = 1 + RULE_ID_WIDTH;
  localparam int SET_W          = NUM_RULE_ID * SLOT_W;
  localparam int SLOT_VALID_OFF = 0;
  localparam int SLOT_ID_OFF    = 1;
  typedef enum logic [1:0] {IDLE, MERGE, DONE} isect_state_t;
endpackage

// File: rtl/rule_set_intersect.sv
// rule_set_intersect: merge-intersects two sorted rule-ID sets, reporting set, match, best ID and count
// Ports: clk/reset (sync, active-high); in_valid/in_ready + set_a/set_b input handshake;
//        out_valid/out_ready + out_set/out_match/out_best/out_count registered result handshake.
module rule_set_intersect #(
  parameter int NUM_RULE_ID   = rule_pkg::NUM_RULE_ID,
  parameter int RULE_ID_WIDTH = rule_pkg::RULE_ID_WIDTH,
  parameter int SET_W         = NUM_RULE_ID * (1 + RULE_ID_WIDTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SET_W-1:0]                   set_a,
  input  logic [SET_W-1:0]                   set_b,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SET_W-1:0]                   out_set,
  output logic                               out_match,
  output logic [RULE_ID_WIDTH-1:0]           out_best,
  output logic [$clog2(NUM_RULE_ID+1)-1:0]   out_count
);
  import rule_pkg::*;
  localparam int SLOT_BITS = 1 + RULE_ID_WIDTH;
  localparam int PTR_W = $clog2(NUM_RULE_ID) + 1;
  localparam int CNT_W = $clog2(NUM_RULE_ID + 1);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_RULE_ID);
  isect_state_t r_state, w_next;
  logic [SET_W-1:0] r_a, r_b, r_set;
  logic [RULE_ID_WIDTH-1:0] r_best, w_ida, w_idb;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_pa, r_pb, w_pa_n, w_pb_n;
  logic [SLOT_BITS-1:0] w_na, w_nb;
  logic w_va, w_vb, w_hit, w_adv_a, w_adv_b, w_empty;
  // Slot 0 sits at the top of the vector, so slot k starts SLOT_BITS*k bits below the MSB.
  always_comb begin
    w_na = r_a[SET_W-1-SLOT_BITS*int'(r_pa[PTR_W-2:0]) -: SLOT_BITS];
    w_nb = r_b[SET_W-1-SLOT_BITS*int'(r_pb[PTR_W-2:0]) -: SLOT_BITS];
    w_va = w_na[SLOT_BITS-1-SLOT_VALID_OFF];
    w_vb = w_nb[SLOT_BITS-1-SLOT_VALID_OFF];
    w_ida = w_na[SLOT_BITS-1-SLOT_ID_OFF -: RULE_ID_WIDTH];
    w_idb = w_nb[SLOT_BITS-1-SLOT_ID_OFF -: RULE_ID_WIDTH];
    w_hit = w_va && w_vb && w_ida == w_idb;
    w_adv_a = !w_va || w_hit || (w_vb && w_ida < w_idb);
    w_adv_b = !w_vb || w_hit || (w_va && w_ida > w_idb);
    w_pa_n = r_pa + PTR_W'(w_adv_a);
    w_pb_n = r_pb + PTR_W'(w_adv_b);
  end
  // Valid slots are right-justified, so a set is empty exactly when its last slot is invalid.
  assign w_empty = !set_a[SLOT_BITS-1-SLOT_VALID_OFF] || !set_b[SLOT_BITS-1-SLOT_VALID_OFF];
  always_comb begin
    w_next = r_state;
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_empty ? DONE : MERGE;
      MERGE:   if (w_pa_n == PTR_END || w_pb_n == PTR_END) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_set <= '0;
      r_best <= '0;
      r_cnt <= '0;
      r_pa <= '0;
      r_pb <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a <= set_a;
        r_b <= set_b;
        r_set <= '0;
        r_best <= '0;
        r_cnt <= '0;
        r_pa <= '0;
        r_pb <= '0;
      end else if (r_state == MERGE) begin
        r_pa <= w_pa_n;
        r_pb <= w_pb_n;
        if (w_hit) begin
          r_set <= {r_set[SET_W-SLOT_BITS-1:0], 1'b1, w_ida};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == '0) r_best <= w_ida;
        end
      end
    end
  end
  assign out_set = r_set;
  assign out_match = r_cnt != '0;
  assign out_best = r_best;
  assign out_count = r_cnt;
endmodule

// File: tb/tb_rule_set_intersect.sv
// tb_rule_set_intersect: directed and random transactions checked against a set-level reference model
module tb_rule_set_intersect;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] set_a = '0, set_b = '0;
  logic in_ready, out_valid, out_match;
  logic [31:0] out_set;
  logic [2:0] out_best;
  logic [3:0] out_count;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  rule_set_intersect dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .set_a(set_a), .set_b(set_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_set(out_set), .out_match(out_match), .out_best(out_best), .out_count(out_count)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ids_of(input logic [31:0] s);
    logic [7:0] m;
    logic [3:0] nib;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      nib = s[31-4*k -: 4];
      if (nib[3]) m[nib[2:0]] = 1'b1;
    end
    return m;
  endfunction
  function automatic logic [31:0] enc(input logic [7:0] m);
    logic [31:0] r;
    int slot;
    r = '0;
    slot = 8 - $countones(m);
    for (int id = 0; id < 8; id++)
      if (m[id]) begin
        r[31-4*slot -: 4] = {1'b1, 3'(id)};
        slot++;
      end
    return r;
  endfunction
  function automatic logic [2:0] lowest(input logic [7:0] m);
    for (int id = 7; id >= 0; id--) if (m[id]) lowest = 3'(id);
    if (m == '0) lowest = '0;
  endfunction
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [7:0] mi;
    int lat;
    bit empty;
    mi = ids_of(a) & ids_of(b);
    empty = ids_of(a) == '0 || ids_of(b) == '0;
    chk("in_ready_idle", in_ready, 1);
    set_a = a;
    set_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    set_a = $urandom;
    set_b = $urandom;
    chk("in_ready_busy", in_ready, 0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    if (empty) chk("empty_latency", lat, 1);
    else chk("latency_le16", 32'(lat <= 16), 1);
    chk("out_valid", out_valid, 1);
    chk("out_set", out_set, enc(mi));
    chk("out_match", out_match, mi != '0);
    chk("out_best", out_best, lowest(mi));
    chk("out_count", out_count, $countones(mi));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_set", out_set, enc(mi));
      chk("hold_count", out_count, $countones(mi));
      chk("hold_best", out_best, lowest(mi));
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask
  initial begin
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_set", out_set, 0);
    chk("rst_out_match", out_match, 0);
    chk("rst_out_best", out_best, 0);
    chk("rst_out_count", out_count, 0);
    reset = 1'b0;
    step();
    txn(32'h000008BF, 32'h00008BCF, 0);
    txn(32'h0000000D, 32'h000008BF, 0);
    txn(32'h00000000, 32'h89ABCDEF, 0);
    txn(32'h89ABCDEF, 32'h89ABCDEF, 0);
    txn(32'h00000BCE, 32'h00000000, 0);
    txn(32'h0000000F, 32'h0000000F, 0);
    txn(32'h00008BCF, 32'h000008BF, 10);
    set_a = 32'h89ABCDEF;
    set_b = 32'h89ABCDEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pre_reset_valid", out_valid, 0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_count", out_count, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("after_reset_quiet", out_valid, 0);
    end
    txn(32'h000009DF, 32'h000009DE, 0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ma, mb;
      ma = 8'($urandom) & (i % 7 == 0 ? 8'h00 : 8'($urandom | $urandom));
      mb = 8'($urandom | $urandom);
      txn(enc(ma), enc(mb), $urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
